// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state enum, branch-code encodings and default widths.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_FWD  = 2'b01;
    localparam logic [1:0] BR_BWD  = 2'b10;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-PC computation: sequential step or relative branch.
// Magnitude is zero-extended; arithmetic wraps modulo 2^PC_W.
module pc_next
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      branch_code,
    input  logic [7:0]      branch_mag,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] mag_ext;

    assign mag_ext = PC_W'(branch_mag);

    always_comb begin
        next_pc = pc + PC_W'(1);
        unique case (branch_code)
            BR_FWD:  next_pc = pc + mag_ext;
            BR_BWD:  next_pc = pc - mag_ext;
            default: next_pc = pc + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: IDLE/RUN/HALTED FSM, program counter and a
// saturating retired-instruction counter; all outputs come from registers.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic [1:0]       BranchCode,
    input  logic [7:0]       BranchMag,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);

    state_t           state_p0, state_nxt;
    logic [PC_W-1:0]  pc_p0, pc_nxt, pc_step;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc          (pc_p0),
        .branch_code (BranchCode),
        .branch_mag  (BranchMag),
        .next_pc     (pc_step)
    );

    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        cnt_nxt   = cnt_p0;
        unique case (state_p0)
            RUN: begin
                // A stalled instruction is not retired, so halt/branch wait too
                if (!Stall) begin
                    cnt_nxt = sat_inc(cnt_p0);
                    if (Halt) state_nxt = HALTED;
                    else      pc_nxt    = pc_step;
                end
            end
            default: begin
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = StartAddr;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // stage p0: architectural state registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_p0 <= IDLE;
            pc_p0    <= '0;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    assign PC         = pc_p0;
    assign InstrCount = cnt_p0;
    assign Running    = (state_p0 == RUN);
    assign Done       = (state_p0 == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic checked
// against a behavioural model; a narrow-counter instance shows saturation.
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int SAT_W = 6;

    logic             Clk;
    logic             Reset, Start, Stall, Halt;
    logic [PC_W-1:0]  StartAddr;
    logic [1:0]       BranchCode;
    logic [7:0]       BranchMag;
    logic [PC_W-1:0]  PC, PC_s;
    logic             Running, Done, Running_s, Done_s;
    logic [CNT_W-1:0] InstrCount;
    logic [SAT_W-1:0] InstrCount_s;

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 run, 2 halted
    int     m_state = 0;
    int     m_pc    = 0;
    longint m_cnt   = 0;

    pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchCode(BranchCode), .BranchMag(BranchMag),
        .PC(PC), .Running(Running), .Done(Done), .InstrCount(InstrCount)
    );

    pc_sequencer #(.PC_W(PC_W), .CNT_W(SAT_W)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchCode(BranchCode), .BranchMag(BranchMag),
        .PC(PC_s), .Running(Running_s), .Done(Done_s), .InstrCount(InstrCount_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge();
        if (Reset) begin
            m_state = 0; m_pc = 0; m_cnt = 0;
        end else if (m_state == 1) begin
            if (!Stall) begin
                m_cnt++;
                if (Halt)                 m_state = 2;
                else if (BranchCode == 1) m_pc = (m_pc + BranchMag) % 1024;
                else if (BranchCode == 2) m_pc = (m_pc - BranchMag + 1024) % 1024;
                else                      m_pc = (m_pc + 1) % 1024;
            end
        end else if (Start) begin
            m_state = 1; m_pc = StartAddr; m_cnt = 0;
        end
    endtask

    task automatic step(input bit rst, input bit st, input int sa, input bit stl,
                        input bit hlt, input int bc, input int mag);
        Reset = rst; Start = st; StartAddr = PC_W'(sa); Stall = stl;
        Halt = hlt; BranchCode = 2'(bc); BranchMag = 8'(mag);
        @(posedge Clk);
        model_edge();
        #1;
        chk("pc",      32'(PC),           32'(m_pc));
        chk("running", 32'(Running),      32'(m_state == 1));
        chk("done",    32'(Done),         32'(m_state == 2));
        chk("cnt",     32'(InstrCount),   32'(sat(m_cnt, CNT_W)));
        chk("sat_pc",  32'(PC_s),         32'(m_pc));
        chk("sat_cnt", 32'(InstrCount_s), 32'(sat(m_cnt, SAT_W)));
    endtask

    task automatic run(input int bc, input int mag);
        step(0, 0, 0, 0, 0, bc, mag);
    endtask

    initial begin
        Reset = 1; Start = 0; StartAddr = '0; Stall = 0; Halt = 0;
        BranchCode = '0; BranchMag = '0;

        // reset state
        step(1, 1, 'h155, 1, 1, 1, 3);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_run", 32'(Running), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_cnt", 32'(InstrCount), 0);
        step(0, 0, 'h155, 0, 0, 0, 0);
        chk("idle_hold_pc", 32'(PC), 0);

        // sequential run from 0x010
        step(0, 1, 'h010, 0, 0, 0, 0);
        chk("start_pc", 32'(PC), 'h010);
        run(0, 0); run(3, 0); run(0, 0);
        chk("seq_pc", 32'(PC), 'h013);
        chk("seq_cnt", 32'(InstrCount), 3);
        chk("seq_run", 32'(Running), 1);
        step(0, 1, 'h200, 0, 0, 0, 0);
        chk("start_ignored", 32'(PC), 'h014);

        // forward then backward branch
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 'h020, 0, 0, 0, 0);
        run(1, 'h05);
        chk("fwd_pc", 32'(PC), 'h025);
        run(2, 'h0A);
        chk("bwd_pc", 32'(PC), 'h01B);
        run(1, 0);
        chk("selfloop_pc", 32'(PC), 'h01B);

        // wrap-around
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 'h3FE, 0, 0, 0, 0);
        run(0, 0);
        chk("wrap1_pc", 32'(PC), 'h3FF);
        run(0, 0);
        chk("wrap2_pc", 32'(PC), 'h000);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 'h003, 0, 0, 0, 0);
        run(2, 'h08);
        chk("wrap_bwd_pc", 32'(PC), 'h3FB);
        run(1, 'hFF);
        chk("wrap_fwd_pc", 32'(PC), 'h0FA);

        // stall with halt, then halt
        step(0, 0, 0, 1, 1, 1, 9);
        step(0, 0, 0, 1, 1, 2, 9);
        chk("stall_pc", 32'(PC), 'h0FA);
        chk("stall_cnt", 32'(InstrCount), 2);
        chk("stall_run", 32'(Running), 1);
        step(0, 0, 0, 0, 1, 1, 9);
        chk("halt_done", 32'(Done), 1);
        chk("halt_pc", 32'(PC), 'h0FA);
        chk("halt_cnt", 32'(InstrCount), 3);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("halted_hold_pc", 32'(PC), 'h0FA);

        // restart from HALTED, then reset mid-run with Start
        step(0, 1, 'h100, 0, 0, 0, 0);
        chk("restart_run", 32'(Running), 1);
        chk("restart_pc", 32'(PC), 'h100);
        chk("restart_cnt", 32'(InstrCount), 0);
        run(0, 0);
        step(1, 1, 'h2AA, 0, 1, 0, 0);
        chk("midrst_pc", 32'(PC), 0);
        chk("midrst_run", 32'(Running), 0);
        chk("midrst_done", 32'(Done), 0);

        // counter saturation (narrow instance saturates at 63)
        step(0, 1, 'h000, 0, 0, 0, 0);
        for (int i = 0; i < 70; i++) run(0, 0);
        chk("sat_narrow", 32'(InstrCount_s), 63);
        chk("sat_wide", 32'(InstrCount), 70);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 60) == 0, ($urandom % 6) == 0, int'($urandom % 1024),
                 ($urandom % 4) == 0, ($urandom % 25) == 0, int'($urandom % 4),
                 (($urandom % 8) == 0) ? 0 : int'($urandom % 256));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
